// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: buffers fetched words while decode stalls,
// tags each word with a word-addressed PC rebuilt from a shadow counter, and
// discards the stale in-flight word after reset and after every taken branch.
module fetch_queue #(
    parameter int DEPTH            = 4,
    parameter int DROP_AFTER_FLUSH = 1,
    parameter int DROP_AFTER_RESET = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_valid_i,
    input  logic [31:0]                fetch_inst_i,
    input  logic                       flush_i,
    input  logic [31:0]                flush_pc_i,
    output logic                       fetch_full_o,
    output logic                       dec_valid_o,
    output logic [31:0]                dec_inst_o,
    output logic [31:0]                dec_pc_o,
    input  logic                       dec_ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = 8;

    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [DW-1:0] DROP_FLUSH = DW'(DROP_AFTER_FLUSH);
    localparam logic [DW-1:0] DROP_RESET = DW'(DROP_AFTER_RESET);

    logic [CW-1:0] count_q,     count_d;
    logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [31:0]   shadow_pc_q, shadow_pc_d;
    logic [DW-1:0] drop_cnt_q,  drop_cnt_d;
    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   inst_mem_d [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   pc_mem_d   [DEPTH];

    logic empty_s;
    logic push_s;
    logic drop_s;
    logic pop_s;

    // Handshake decode: flush blocks every transfer, a full queue refuses pushes even when popping.
    always_comb begin
        empty_s      = (count_q == {CW{1'b0}});
        fetch_full_o = (count_q == FULL_CNT);
        dec_valid_o  = !empty_s && !flush_i;
        pop_s        = dec_valid_o && dec_ready_i;
        drop_s       = fetch_valid_i && !flush_i && (drop_cnt_q != {DW{1'b0}});
        push_s       = fetch_valid_i && !flush_i && (drop_cnt_q == {DW{1'b0}}) && !fetch_full_o;
        count_o      = count_q;
    end

    // Show-ahead head read; an empty queue presents zeros rather than stale storage.
    always_comb begin
        dec_inst_o = 32'h0000_0000;
        dec_pc_o   = 32'h0000_0000;
        if (!empty_s) begin
            dec_inst_o = inst_mem_q[rd_ptr_q];
            dec_pc_o   = pc_mem_q[rd_ptr_q];
        end else begin
            dec_inst_o = 32'h0000_0000;
            dec_pc_o   = 32'h0000_0000;
        end
    end

    // Next-state for occupancy, pointers, shadow PC and drop window; flush overrides all.
    always_comb begin
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        shadow_pc_d = shadow_pc_q;
        drop_cnt_d  = drop_cnt_q;
        if (flush_i) begin
            count_d     = {CW{1'b0}};
            rd_ptr_d    = {AW{1'b0}};
            wr_ptr_d    = {AW{1'b0}};
            shadow_pc_d = flush_pc_i;
            drop_cnt_d  = DROP_FLUSH;
        end else begin
            if (push_s) begin
                wr_ptr_d    = wr_ptr_q + AW'(1);
                shadow_pc_d = shadow_pc_q + 32'h0000_0001;
            end else if (drop_s) begin
                drop_cnt_d  = drop_cnt_q - DW'(1);
            end else begin
                wr_ptr_d    = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage write path: only the slot at the write pointer changes, and only on a push.
    always_comb begin
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        if (push_s) begin
            inst_mem_d[wr_ptr_q] = fetch_inst_i;
            pc_mem_d[wr_ptr_q]   = shadow_pc_q;
        end else begin
            inst_mem_d = inst_mem_q;
            pc_mem_d   = pc_mem_q;
        end
    end

    // Control state registers with asynchronous reset; reset opens the post-reset drop window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= {CW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            wr_ptr_q    <= {AW{1'b0}};
            shadow_pc_q <= 32'h0000_0000;
            drop_cnt_q  <= DROP_RESET;
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            shadow_pc_q <= shadow_pc_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Queue storage; contents are masked by the count, so no reset is needed.
    always_ff @(posedge clk) begin
        inst_mem_q <= inst_mem_d;
        pc_mem_q   <= pc_mem_d;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus pushes hand-computed {inst, pc}
// expectations; a negedge monitor pops and compares on every decode handshake.
module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        fetch_valid_i;
    logic [31:0] fetch_inst_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        fetch_full_o;
    logic        dec_valid_o;
    logic [31:0] dec_inst_o;
    logic [31:0] dec_pc_o;
    logic        dec_ready_i;
    logic [2:0]  count_o;

    int checks;
    int errors;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];

    fetch_queue #(.DEPTH(4), .DROP_AFTER_FLUSH(1), .DROP_AFTER_RESET(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_valid_i (fetch_valid_i),
        .fetch_inst_i  (fetch_inst_i),
        .flush_i       (flush_i),
        .flush_pc_i    (flush_pc_i),
        .fetch_full_o  (fetch_full_o),
        .dec_valid_o   (dec_valid_o),
        .dec_inst_o    (dec_inst_o),
        .dec_pc_o      (dec_pc_o),
        .dec_ready_i   (dec_ready_i),
        .count_o       (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        e.inst = inst;
        e.pc   = pc;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        step();
        rst_n = 1'b1;
    endtask

    // Monitor: every decode handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && dec_valid_o && dec_ready_i) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got inst 0x%08h pc 0x%08h expected none", dec_inst_o, dec_pc_o);
            end else begin
                e = exp_q.pop_front();
                check("dec_inst", dec_inst_o, e.inst);
                check("dec_pc", dec_pc_o, e.pc);
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_inst_i  = 32'h0;
        flush_i       = 1'b0;
        flush_pc_i    = 32'h0;
        dec_ready_i   = 1'b0;
        #12;
        check("rst_valid", {31'h0, dec_valid_o}, 32'h0);
        check("rst_count", {29'h0, count_o}, 32'h0);
        check("rst_full", {31'h0, fetch_full_o}, 32'h0);
        check("rst_inst", dec_inst_o, 32'h0);
        check("rst_pc", dec_pc_o, 32'h0);
        step();
        rst_n = 1'b1;

        // Post-reset drop, then two words flowing straight through.
        dec_ready_i = 1'b1; fetch_valid_i = 1'b1; fetch_inst_i = 32'hA0;
        step();
        check("t1_count_drop", {29'h0, count_o}, 32'd0);
        fetch_inst_i = 32'hA1; expect_word(32'hA1, 32'd0);
        step();
        check("t1_count_a1", {29'h0, count_o}, 32'd1);
        fetch_inst_i = 32'hA2; expect_word(32'hA2, 32'd1);
        step();
        check("t1_count_a2", {29'h0, count_o}, 32'd1);
        fetch_valid_i = 1'b0;
        step();
        check("t1_count_end", {29'h0, count_o}, 32'd0);

        // Fill to full with decode stalled; extra words refused.
        do_reset();
        dec_ready_i = 1'b0; fetch_valid_i = 1'b1; fetch_inst_i = 32'hD0;
        step();
        for (int i = 0; i < 6; i++) begin
            fetch_inst_i = 32'hB0 + 32'(i);
            if (i < 4) expect_word(32'hB0 + 32'(i), 32'(i));
            step();
        end
        check("t2_count_full", {29'h0, count_o}, 32'd4);
        check("t2_full", {31'h0, fetch_full_o}, 32'd1);
        fetch_valid_i = 1'b0; dec_ready_i = 1'b1;
        step();
        check("t2_count_pop1", {29'h0, count_o}, 32'd3);
        check("t2_full_drop", {31'h0, fetch_full_o}, 32'd0);
        for (int i = 0; i < 3; i++) step();
        check("t2_count_drained", {29'h0, count_o}, 32'd0);

        // Full queue with simultaneous pop and push attempt: no bypass.
        do_reset();
        dec_ready_i = 1'b0; fetch_valid_i = 1'b1; fetch_inst_i = 32'hD1;
        step();
        for (int i = 0; i < 4; i++) begin
            fetch_inst_i = 32'hC0 + 32'(i);
            expect_word(32'hC0 + 32'(i), 32'(i));
            step();
        end
        fetch_inst_i = 32'hC4; dec_ready_i = 1'b1;
        step();
        check("t3_count_nobypass", {29'h0, count_o}, 32'd3);

        // Flush with three entries queued.
        dec_ready_i = 1'b0; flush_i = 1'b1; flush_pc_i = 32'h40; fetch_inst_i = 32'hEE;
        #1;
        check("t4_valid_in_flush", {31'h0, dec_valid_o}, 32'd0);
        exp_q.delete();
        step();
        flush_i = 1'b0;
        check("t4_count_flushed", {29'h0, count_o}, 32'd0);
        dec_ready_i = 1'b1; fetch_inst_i = 32'hE0;
        step();
        fetch_inst_i = 32'hE1; expect_word(32'hE1, 32'h40);
        step();
        fetch_inst_i = 32'hE2; expect_word(32'hE2, 32'h41);
        step();
        fetch_valid_i = 1'b0;
        step();

        // Back-to-back flushes (second restarts drop window), then PC wrap.
        flush_i = 1'b1; flush_pc_i = 32'h100;
        step();
        flush_pc_i = 32'hFFFF_FFFF;
        step();
        flush_i = 1'b0; fetch_valid_i = 1'b1; fetch_inst_i = 32'hF0;
        step();
        fetch_inst_i = 32'hF1; expect_word(32'hF1, 32'hFFFF_FFFF);
        step();
        fetch_inst_i = 32'hF2; expect_word(32'hF2, 32'h0);
        step();
        fetch_valid_i = 1'b0;
        step();
        check("t5_count_end", {29'h0, count_o}, 32'd0);

        // Asynchronous reset between edges with two entries queued.
        dec_ready_i = 1'b0; fetch_valid_i = 1'b1; fetch_inst_i = 32'h60;
        step();
        fetch_inst_i = 32'h61;
        step();
        fetch_valid_i = 1'b0;
        check("t6_count_pre", {29'h0, count_o}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid_async", {31'h0, dec_valid_o}, 32'd0);
        check("t6_count_async", {29'h0, count_o}, 32'd0);
        check("t6_full_async", {31'h0, fetch_full_o}, 32'd0);
        check("t6_inst_async", dec_inst_o, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue between the Fetch stage and the decode stage of the hybrid ARM/MIPS pipeline.
- Absorbs fetched words while decode is stalled, and tags each word with its word-addressed PC, rebuilt from a shadow counter.
- Discards the stale word after reset and after each taken branch (PCsrc), so no instruction executes twice.
- Signals back-pressure to Fetch.

Parameters:
- DEPTH, 4: queue entries; power of two, 2..16.
- DROP_AFTER_FLUSH, 1: fetch words discarded after a flush (the instruction-memory read latency).
- DROP_AFTER_RESET, 1: fetch words discarded after reset release.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_valid_i  in  1  Fetch presents a word this cycle.
- fetch_inst_i  in  32  instruction word from Fetch.
- flush_i  in  1  taken branch (same cycle Fetch samples PCsrc=1).
- flush_pc_i  in  32  branch target (the PCalu value given to Fetch).
- fetch_full_o  out  1  queue full; Fetch must freeze its PC.
- dec_valid_o  out  1  head entry valid.
- dec_inst_o  out  32  head instruction.
- dec_pc_o  out  32  head word address.
- dec_ready_i  in  1  decode consumes the head this cycle.
- count_o  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - count=0, rd/wr pointers=0, shadow_pc=0, drop_cnt=DROP_AFTER_RESET.
  - Outputs: dec_valid_o=0, dec_inst_o=0, dec_pc_o=0, fetch_full_o=0, count_o=0.
  - Storage contents need not be cleared, but dec_inst_o/dec_pc_o read 0 whenever count=0.
- Reset asserted mid-operation discards all entries immediately; no partial update on release.
- Show-ahead read: dec_valid_o = (count!=0) && !flush_i. dec_inst_o/dec_pc_o come combinationally from the head storage register; there is no extra latency.
- Write (push) occurs when fetch_valid_i && !flush_i && drop_cnt==0 && count<DEPTH. On push:
  - entry = {fetch_inst_i, shadow_pc};
  - shadow_pc += 1 (32-bit, wraps 0xFFFFFFFF -> 0);
  - wr pointer advances modulo DEPTH.
- Drop occurs when fetch_valid_i && !flush_i && drop_cnt!=0. The word is discarded, drop_cnt decrements, and shadow_pc is unchanged.
- Read (pop) occurs when dec_valid_o && dec_ready_i; rd pointer advances modulo DEPTH.
- Simultaneous push and pop: count unchanged. Legal when 0<count<DEPTH.
- When count==DEPTH:
  - fetch_full_o=1 and pushes are refused, even if a pop occurs in the same cycle (no bypass).
  - A refused word is not consumed; Fetch holds it.
- Push into an empty queue: visible at dec_* the following cycle (latency 1 from fetch to decode).
- fetch_full_o = (count==DEPTH), combinational from registered count.
- Flush (flush_i=1) has priority over everything in that cycle:
  - count:=0, pointers:=0, shadow_pc:=flush_pc_i, drop_cnt:=DROP_AFTER_FLUSH;
  - no push, no pop; dec_valid_o forced 0 in that cycle.
- Flush during a drop window restarts drop_cnt at DROP_AFTER_FLUSH.
- Back-to-back flushes: the last one wins.
- fetch_valid_i=0 cycles change nothing except pops.

Test Plan:
- Reset release, fetch words 0xA0,0xA1,0xA2 on consecutive cycles, dec_ready_i=1 -> 0xA0 dropped; decode sees 0xA1 @pc 0 then 0xA2 @pc 1; count_o never exceeds 1.
- dec_ready_i=0, push 6 words (DEPTH=4) -> count_o=4 and fetch_full_o=1 after 4 pushes; words 5–6 refused. Raise dec_ready_i -> 4 words drained in order with pc 0..3; fetch_full_o drops the cycle after the first pop.
- Full queue, dec_ready_i=1 and fetch_valid_i=1 same cycle -> pop happens, push refused, count_o=3.
- Queue holding 3 entries, flush_i=1, flush_pc_i=0x40 -> dec_valid_o=0 that cycle, count_o=0 next. Next fetch word is dropped; the following word appears with dec_pc_o=0x40, then 0x41.
- Flush with flush_pc_i=0xFFFFFFFF, push 2 words after the drop -> pcs 0xFFFFFFFF then 0x00000000.
- Assert rst_n=0 asynchronously between edges while count_o=2 -> dec_valid_o, count_o and fetch_full_o go 0 immediately, without waiting for a clock edge.
